// File: rtl/pipelined_addsub_if.sv
// Streaming handshake bundle for pipelined_addsub: the operand side and the result side,
// each with valid/ready.
interface pipelined_addsub_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ov;

    modport master (
        output in_valid, a, b, ci, sub, out_ready,
        input  in_ready, out_valid, s, co, ov
    );

    modport slave (
        input  in_valid, a, b, ci, sub, out_ready,
        output in_ready, out_valid, s, co, ov
    );
endinterface

// File: rtl/pipelined_addsub.sv
// Carry-split pipelined adder/subtractor: one CW-bit chunk per stage, with a registered carry between stages.
// Optional signed saturation on overflow when PIPELINED_ADDSUB_SAT_EN is defined.
module pipelined_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    pipelined_addsub_if.slave bus
);
    localparam int CW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    logic             en;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic             ov_raw;

    // Registers after stage k; the operands travel along so upper chunks meet their carry.
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] cy_q;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  r_q [STAGES];

    logic [STAGES-1:0] src_v;
    logic [STAGES-1:0] src_c;
    logic [WIDTH-1:0]  src_a [STAGES];
    logic [WIDTH-1:0]  src_b [STAGES];
    logic [WIDTH-1:0]  src_r [STAGES];
    logic [WIDTH-1:0]  nxt_r [STAGES];
    logic [STAGES-1:0] nxt_c;
    logic [CW:0]       csum;

    assign en           = bus.out_ready || !bus.out_valid;
    assign bus.in_ready = en;
    assign b_eff        = bus.b ^ {WIDTH{bus.sub}};
    assign cin_eff      = bus.ci ^ bus.sub;

    always_comb begin
        src_v    = '0;
        src_c    = '0;
        nxt_c    = '0;
        csum     = '0;
        src_v[0] = bus.in_valid;
        src_c[0] = cin_eff;
        src_a[0] = bus.a;
        src_b[0] = b_eff;
        src_r[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            src_v[k] = vld_q[k-1];
            src_c[k] = cy_q[k-1];
            src_a[k] = a_q[k-1];
            src_b[k] = b_q[k-1];
            src_r[k] = r_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            csum = {1'b0, src_a[k][k*CW +: CW]} + {1'b0, src_b[k][k*CW +: CW]}
                 + {{CW{1'b0}}, src_c[k]};
            nxt_r[k]              = src_r[k];
            nxt_r[k][k*CW +: CW]  = csum[CW-1:0];
            nxt_c[k]              = csum[CW];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
            cy_q  <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                r_q[k] <= '0;
            end
        end else if (en) begin
            vld_q <= src_v;
            cy_q  <= nxt_c;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= src_a[k];
                b_q[k] <= src_b[k];
                r_q[k] <= nxt_r[k];
            end
        end
    end

    assign ov_raw = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1]) &&
                    (r_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);

    assign bus.out_valid = vld_q[LAST];
    assign bus.co        = cy_q[LAST];
    assign bus.ov        = ov_raw;
`ifdef PIPELINED_ADDSUB_SAT_EN
    // Clamp toward the sign of a; co/ov still describe the unsaturated sum.
    assign bus.s = ov_raw ? {a_q[LAST][WIDTH-1], {(WIDTH-1){~a_q[LAST][WIDTH-1]}}}
                          : r_q[LAST];
`else
    assign bus.s = r_q[LAST];
`endif
endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed plus scoreboard bench for pipelined_addsub (WIDTH=32, STAGES=4).
module tb_pipelined_addsub;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipelined_addsub_if #(.WIDTH(32)) bus ();
    pipelined_addsub #(.WIDTH(32), .STAGES(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int total = 0;
    int bad   = 0;
    int n_out = 0;
    logic [33:0] sb [$];
    logic        obs_valid, obs_ready, obs_co, obs_ov;
    logic [31:0] obs_s;

    function automatic logic [33:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                          input logic mci, input logic msub);
        logic [31:0] be;
        logic [32:0] t;
        logic        ovr;
        logic [31:0] rs;
        be  = mb ^ {32{msub}};
        t   = {1'b0, ma} + {1'b0, be} + {32'd0, mci ^ msub};
        ovr = (ma[31] == be[31]) && (t[31] != ma[31]);
        rs  = t[31:0];
`ifdef PIPELINED_ADDSUB_SAT_EN
        if (ovr) rs = ma[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        return {rs, t[32], ovr};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock: drive at negedge, sample just after, account handshakes, then the edge.
    task automatic step(input logic v, input logic [31:0] ta, input logic [31:0] tb,
                        input logic tci, input logic tsub, input logic ordy,
                        input logic rst, output logic acc);
        logic [33:0] e;
        @(negedge clk);
        rst_n         = !rst;
        bus.in_valid  = v;
        bus.a         = ta;
        bus.b         = tb;
        bus.ci        = tci;
        bus.sub       = tsub;
        bus.out_ready = ordy;
        #1;
        obs_valid = bus.out_valid;
        obs_ready = bus.in_ready;
        obs_s     = bus.s;
        obs_co    = bus.co;
        obs_ov    = bus.ov;
        acc       = 1'b0;
        if (!rst) begin
            if (obs_valid && ordy) begin
                if (sb.size() == 0) begin
                    chk("spurious_output", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("result", {30'd0, obs_s, obs_co, obs_ov}, {30'd0, e});
                    n_out++;
                end
            end
            if (v && obs_ready) begin
                sb.push_back(model(ta, tb, tci, tsub));
                acc = 1'b1;
            end
        end
        @(posedge clk);
    endtask

    task automatic idle();
        logic dummy;
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, dummy);
    endtask

    initial begin
        logic        acc;
        logic [31:0] ra [8];
        logic [31:0] rb [8];
        logic        rci [8];
        logic        rsub [8];
        int          idx;
        logic        ordy;

        // Reset
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, acc);
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, acc);
        idle();
        chk("rst_out_valid", {63'd0, obs_valid}, 64'd0);
        chk("rst_s", {32'd0, obs_s}, 64'd0);
        chk("rst_co", {63'd0, obs_co}, 64'd0);
        chk("rst_ov", {63'd0, obs_ov}, 64'd0);
        chk("rst_in_ready", {63'd0, obs_ready}, 64'd1);

        // Carry ripples across every chunk; latency exactly 4
        step(1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, acc);
        chk("carry_accept", {63'd0, acc}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("carry_early_valid", {63'd0, obs_valid}, 64'd0);
        end
        idle();
        chk("carry_valid", {63'd0, obs_valid}, 64'd1);
        chk("carry_s", {32'd0, obs_s}, 64'h0);
        chk("carry_co", {63'd0, obs_co}, 64'd1);
        chk("carry_ov", {63'd0, obs_ov}, 64'd0);

        // Overflow and subtract, back to back
        step(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 1'b0, acc);
        step(1'b1, 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 1'b1, 1'b0, acc);
        step(1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b1, 1'b0, acc);
        idle();
        chk("b2b_not_yet", {63'd0, obs_valid}, 64'd0);
        idle();
        chk("ovf_valid", {63'd0, obs_valid}, 64'd1);
`ifdef PIPELINED_ADDSUB_SAT_EN
        chk("ovf_s", {32'd0, obs_s}, {32'd0, 32'h7FFF_FFFF});
`else
        chk("ovf_s", {32'd0, obs_s}, {32'd0, 32'h8000_0000});
`endif
        chk("ovf_co", {63'd0, obs_co}, 64'd0);
        chk("ovf_ov", {63'd0, obs_ov}, 64'd1);
        idle();
        chk("sub_neg_valid", {63'd0, obs_valid}, 64'd1);
        chk("sub_neg_s", {32'd0, obs_s}, {32'd0, 32'hFFFF_FFFE});
        chk("sub_neg_co", {63'd0, obs_co}, 64'd0);
        chk("sub_neg_ov", {63'd0, obs_ov}, 64'd0);
        idle();
        chk("sub_ovf_valid", {63'd0, obs_valid}, 64'd1);
`ifdef PIPELINED_ADDSUB_SAT_EN
        chk("sub_ovf_s", {32'd0, obs_s}, {32'd0, 32'h8000_0000});
`else
        chk("sub_ovf_s", {32'd0, obs_s}, {32'd0, 32'h7FFF_FFFF});
`endif
        chk("sub_ovf_co", {63'd0, obs_co}, 64'd1);
        chk("sub_ovf_ov", {63'd0, obs_ov}, 64'd1);
        idle();
        chk("drained_after_directed", {63'd0, obs_valid}, 64'd0);

        // Backpressure: 8 random ops, out_ready low for cycles 6..8
        for (int i = 0; i < 8; i++) begin
            ra[i]   = $urandom;
            rb[i]   = $urandom;
            rci[i]  = 1'($urandom_range(0, 1));
            rsub[i] = 1'($urandom_range(0, 1));
        end
        ra[2] = 32'h7FFF_FFF0; rb[2] = 32'h0000_0100; rsub[2] = 1'b0;
        n_out = 0;
        idx   = 0;
        for (int cyc = 0; cyc < 40 && (idx < 8 || sb.size() > 0); cyc++) begin
            ordy = !(cyc >= 6 && cyc <= 8);
            if (idx < 8)
                step(1'b1, ra[idx], rb[idx], rci[idx], rsub[idx], ordy, 1'b0, acc);
            else
                step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, ordy, 1'b0, acc);
            chk("bp_in_ready", {63'd0, obs_ready}, {63'd0, !(obs_valid && !ordy)});
            if (acc) idx++;
        end
        chk("bp_all_accepted", 64'(idx), 64'd8);
        chk("bp_result_count", 64'(n_out), 64'd8);
        chk("bp_queue_empty", 64'(sb.size()), 64'd0);

        // Reset mid-stream discards everything in flight
        step(1'b1, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 1'b1, 1'b0, acc);
        step(1'b1, 32'h3333_3333, 32'h0000_0001, 1'b1, 1'b1, 1'b1, 1'b0, acc);
        step(1'b1, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, 1'b0, 1'b1, 1'b0, acc);
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, acc);
        sb.delete();
        for (int i = 0; i < 8; i++) begin
            idle();
            chk("post_rst_no_valid", {63'd0, obs_valid}, 64'd0);
        end
        n_out = 0;
        step(1'b1, 32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, 1'b1, 1'b0, acc);
        chk("post_rst_accept", {63'd0, acc}, 64'd1);
        for (int i = 0; i < 3; i++) idle();
        idle();
        chk("post_rst_valid", {63'd0, obs_valid}, 64'd1);
        chk("post_rst_s", {32'd0, obs_s}, {32'd0, 32'h2222_2222});
        chk("post_rst_count", 64'(n_out), 64'd1);
        chk("final_queue_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised, carry-split pipelined adder/subtractor. Successor to the fixed 32-bit adder_* family.
- Splits a WIDTH-bit add or subtract into STAGES chunks, with a registered carry between chunks.
- Valid/ready handshake on both sides, so it sits directly in streaming datapaths.
- Adds subtract mode and a signed-overflow flag.

Parameters:
WIDTH, 32, operand/sum width; must be a multiple of STAGES
STAGES, 4, pipeline depth = number of carry chunks (CW = WIDTH/STAGES bits each); STAGES >= 1

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset (sampled on clk rising edge)
in_valid  input  1  input operands valid
in_ready  output  1  block accepts operands this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
ci  input  1  carry-in (add) / borrow-in (sub)
sub  input  1  0 = add, 1 = subtract
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
s  output  WIDTH  sum/difference
co  output  1  raw carry-out of the MSB chunk
ov  output  1  signed overflow

Behaviour:
- Arithmetic:
  - b_eff = b ^ {WIDTH{sub}}; cin_eff = ci ^ sub.
  - {co,s} = a + b_eff + cin_eff, computed unsigned.
  - Resulting modes: add = a+b+ci; sub = a-b-ci; co=1 on subtract means no borrow.
  - ov = (a[MSB] == b_eff[MSB]) && (s_raw[MSB] != a[MSB]).
- Pipeline structure:
  - Stage k (0..STAGES-1) adds chunk k of a/b_eff plus the registered carry from stage k-1. Stage 0 uses cin_eff.
  - Upper operand chunks are skewed through delay registers so that they meet their carry.
  - Lower result chunks are deskewed so that all of s, co and ov appear together.
- Latency: exactly STAGES cycles from accept (in_valid && in_ready) to out_valid, with no stalls. STAGES=1 gives a single register stage.
- Throughput: one operation per cycle.
- Handshake:
  - Global enable en = out_ready || !out_valid; in_ready = en (combinational).
  - When en=0, all stage registers, valid bits and outputs hold.
  - Bubbles are not collapsed.
  - A transfer occurs on out_valid && out_ready.
  - Results leave in acceptance order, with no loss and no duplication.
- in_valid=0 while in_ready=1: a bubble (valid bit 0) enters stage 0.
- Outputs s/co/ov are meaningful only while out_valid=1. Upstream must hold a/b/ci/sub stable while in_valid && !in_ready.
- Reset (rst_n=0 at a clock edge):
  - All valid bits clear; out_valid=0; s=0, co=0, ov=0; all stage carry registers 0.
  - in_ready=1 in the first cycle after reset, provided out_valid=0.
- Reset mid-operation: every in-flight operation is discarded. None emerges after reset deasserts.
- Wrap-around: without the optional feature, s wraps modulo 2^WIDTH. co and ov are reported independently.
- Simultaneous accept and emit on the same edge is legal and must sustain full rate.

Optional Feature:
- Macro: PIPELINED_ADDSUB_SAT_EN.
- Defined: in the final stage, if ov=1, s saturates to the signed limit. It becomes 0x7FF..F when a[MSB]=0 and 0x800..0 when a[MSB]=1. co and ov still report the raw values; latency is unchanged.
- Undefined: no saturation logic; s wraps.

Test Plan (WIDTH=32, STAGES=4):
1. Reset: hold rst_n=0 for 2 cycles with out_ready=1 -> out_valid=0, s=0, co=0, ov=0, in_ready=1.
2. Cross-chunk carry: a=0xFFFFFFFF, b=0x00000000, ci=1, sub=0 -> exactly 4 cycles later out_valid=1, s=0x00000000, co=1, ov=0.
3. Overflow: a=0x7FFFFFFF, b=0x00000001, ci=0, sub=0 -> s=0x80000000, co=0, ov=1. With PIPELINED_ADDSUB_SAT_EN: s=0x7FFFFFFF, ov=1.
4. Subtract:
   - a=5, b=7, sub=1, ci=0 -> s=0xFFFFFFFE, co=0, ov=0.
   - a=0x80000000, b=1, sub=1, ci=0 -> s=0x7FFFFFFF, co=1, ov=1 (SAT_EN: s=0x80000000).
5. Backpressure: feed 8 back-to-back random ops, drop out_ready for 3 cycles starting at cycle 6 -> in_ready=0 exactly while out_valid && !out_ready. All 8 results match the reference model, in order, with no duplicates.
6. Reset mid-stream: accept 3 ops, pulse rst_n=0 for 1 cycle -> out_valid=0 on the next cycle, and none of the 3 results ever appear. A new op accepted afterwards emerges 4 cycles later, correct.
